// File: rtl/jtdsp16_pkg.sv
// Shared constants, encodings and helpers for the JTDSP16 interrupt scheduler.
package jtdsp16_pkg;

  localparam int unsigned PIOC_W    = 16;
  localparam int unsigned NSRC      = 3;
  localparam int unsigned IACK_W    = 2;

  localparam int unsigned EN_IRQ    = 0;
  localparam int unsigned EN_IBF    = 1;
  localparam int unsigned EN_OBE    = 2;
  localparam int unsigned CLR_IRQ   = 8;
  localparam int unsigned ST_PEND   = 3;
  localparam int unsigned ST_SHADOW = 6;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IRQ  = 2'd1,
    SRC_IBF  = 2'd2,
    SRC_OBE  = 2'd3
  } irq_src_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  // Fixed priority: IRQ > IBF > OBE.
  function automatic irq_src_e prio_enc(input logic [NSRC-1:0] req);
    irq_src_e win;
    win = SRC_NONE;
    if (req[EN_IRQ])      win = SRC_IRQ;
    else if (req[EN_IBF]) win = SRC_IBF;
    else if (req[EN_OBE]) win = SRC_OBE;
    return win;
  endfunction

endpackage

// File: rtl/jtdsp16_edge_sync.sv
// Multi-flop synchroniser for the asynchronous irq pin with a registered
// rising-edge pulse; free-running on clk.
module jtdsp16_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   rise_q;

  // vld_q gates detection until the chain holds real pin samples, so a pin
  // already high when reset releases is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1] & vld_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/jtdsp16_irq_sched.sv
// Interrupt scheduler: PIOC enables/pending, fixed-priority arbitration and
// shadow/service sequencing with XAAU vector request and iack pulse.
module jtdsp16_irq_sched
  import jtdsp16_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              irq,
  input  logic              siord_full,
  input  logic              siowr_empty,
  input  logic              inst_done,
  input  logic              ireturn,
  input  logic              pioc_wr,
  input  logic [PIOC_W-1:0] pioc_din,
  output logic [PIOC_W-1:0] pioc_dout,
  output logic              irq_take,
  output logic              shadow,
  output logic              iack,
  output logic [1:0]        irq_src
);

  state_e            state_q, state_d;
  irq_src_e          src_q, src_d, win_c;
  logic              take_q, take_d;
  logic              shadow_q;
  logic              iack_q;
  logic [IACK_W-1:0] cnt_q, cnt_d;
  logic              pend0_q;
  logic [NSRC-1:0]   en_q;
  logic [NSRC-1:0]   pend_c, req_c;
  logic              clr_c;
  logic              irq_rise;
  logic              pioc_unused;

  jtdsp16_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (irq),
    .rise_o (irq_rise)
  );

  assign pend_c      = {siowr_empty, siord_full, pend0_q};
  assign req_c       = pend_c & en_q;
  assign pioc_unused = ^{pioc_din[PIOC_W-1:CLR_IRQ+1], pioc_din[CLR_IRQ-1:NSRC]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_NONE;
      take_q   <= 1'b0;
      shadow_q <= 1'b0;
      iack_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (cen) begin
      state_q  <= state_d;
      src_q    <= src_d;
      take_q   <= take_d;
      shadow_q <= (state_d == ST_SERVICE);
      iack_q   <= (cnt_d != '0);
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    take_d  = 1'b0;
    cnt_d   = cnt_q;
    win_c   = prio_enc(req_c);
    if (cnt_q != '0) cnt_d = cnt_q - IACK_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (inst_done && (req_c != '0)) begin
          state_d = ST_SERVICE;
          src_d   = win_c;
          take_d  = 1'b1;
          cnt_d   = IACK_W'(2);
        end
      end
      ST_SERVICE: begin
        if (ireturn) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clr_c = (pioc_wr && pioc_din[CLR_IRQ]) || (take_d && (win_c == SRC_IRQ));
  end

  // A synchronised edge is captured on any clk and wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0_q <= 1'b0;
      en_q    <= '0;
    end else begin
      if (irq_rise)          pend0_q <= 1'b1;
      else if (cen && clr_c) pend0_q <= 1'b0;
      if (cen && pioc_wr)    en_q    <= pioc_din[EN_OBE:EN_IRQ];
    end
  end

  always_comb begin
    pioc_dout                   = '0;
    pioc_dout[ST_SHADOW]        = shadow_q;
    pioc_dout[ST_PEND +: NSRC]  = pend_c;
    pioc_dout[EN_IRQ +: NSRC]   = en_q;
  end

  assign irq_take = take_q;
  assign shadow   = shadow_q;
  assign iack     = iack_q;
  assign irq_src  = src_q;

endmodule

// File: doc/jtdsp16_irq_sched.md
# jtdsp16_irq_sched

Interrupt scheduler for the JTDSP16 core. It collects the three interrupt sources: the external `irq` pin, serial-input buffer full and serial-output buffer empty. It masks them through the PIOC enable bits, arbitrates by fixed priority and sequences entry into and exit from the shadow/service state. It drives the XAAU vector request (`irq_take`), the `shadow` flag, `iack` and the PIOC status readback. It replaces the tied-off `iack`/`irq_latch` paths in the top level.

## Interface
Parameters:
- SYNC_STAGES, 2, number of `clk` flops synchronising the asynchronous `irq` pin (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  instruction-rate clock enable (cen2 domain); all state except the synchroniser advances only when high.
- irq  in  1  external interrupt pin, asynchronous, rising-edge sensitive.
- siord_full  in  1  serial input buffer full, level.
- siowr_empty  in  1  serial output buffer empty, level.
- inst_done  in  1  current instruction retires this cen; PC may be redirected.
- ireturn  in  1  `ireturn` instruction retiring this cen.
- pioc_wr  in  1  PIOC register write strobe, qualified by cen.
- pioc_din  in  16  PIOC write data.
- pioc_dout  out  16  PIOC readback.
- irq_take  out  1  vector request to XAAU: push PC, load the interrupt vector.
- shadow  out  1  high while an interrupt is being serviced.
- iack  out  1  interrupt acknowledge pin.
- irq_src  out  2  source in service: 0 none, 1 IRQ, 2 IBF, 3 OBE.

## Operation
- PIOC write fields:
  - `pioc_din[2:0]` load enable bits en[2:0] (IRQ, IBF, OBE).
  - `pioc_din[8]=1` clears the IRQ pending latch.
  - Other bits are ignored.
- PIOC readback: `pioc_dout = {8'd0, 1'b0, shadow, pend[2:0], en[2:0]}`.
- Pending sources:
  - pend[0]: sticky. Set on a synchronised rising edge of `irq`. Cleared when IRQ is taken or by a software clear. Set wins over a simultaneous clear.
  - pend[1] = `siord_full` and pend[2] = `siowr_empty`: live levels, not latched.
  - Disabling an enable bit does not clear pend[0]. The source is serviced once re-enabled.
- Request: req = pend & en. Priority is IRQ > IBF > OBE.
- FSM states:
  - IDLE → SERVICE on a cen where `inst_done` is set and req is nonzero. On this transition:
    - `irq_take` goes high.
    - `shadow` goes high.
    - `irq_src` latches the winning source.
    - pend[0] is cleared if IRQ won.
    - The iack counter loads 2.
  - SERVICE → IDLE on a cen where `ireturn` is set. `shadow` goes low and `irq_src` goes to 0.
  - In SERVICE, all requests are held off; no nesting.
  - `ireturn` in IDLE is ignored.
- `irq_take` is high for exactly one cen period and clears at the next cen.
- `iack` is high while the counter is nonzero. The counter decrements on each cen, so `iack` stays high for 2 cen periods.

## Timing
- Reset values: `irq_take`, `shadow` and `iack` are 0; `irq_src`, `pioc_dout`, en, pend and synchroniser flops are all 0. Reset is asynchronous and takes effect at any point, including mid-service; the FSM returns to IDLE.
- IRQ latency, pin to pend[0]: SYNC_STAGES+1 `clk` edges, independent of cen.
- Take latency: `irq_take` rises on the first cen edge at which `inst_done` is set and req is nonzero. A request arriving in the same cycle as an `inst_done` is visible on that edge only if it was already registered.
- Back-to-back service:
  - `ireturn` and a pending request on the same cen: exit only.
  - The next take occurs at the earliest following cen with `inst_done`.
- Level sources: IBF/OBE dropping before the take point means no take.
- PIOC writes take effect on the same cen edge. An enable written on edge N is used for arbitration at edge N+1.
- Edges on `irq` during SERVICE are still latched into pend[0]; multiple edges collapse into one pending event.

## Structure
- Shared package `jtdsp16_pkg`:
  - PIOC bit-position constants (EN_IRQ=0, EN_IBF=1, EN_OBE=2, CLR_IRQ=8, ST_PEND=3, ST_SHADOW=6).
  - `irq_src` encodings.
  - FSM state encodings (IDLE=0, SERVICE=1).
- Sub-module `jtdsp16_edge_sync`: SYNC_STAGES-deep synchroniser plus rising-edge detector, clocked by `clk` with no cen.
- The FSM, pend/en registers, priority encoder and iack counter live in this block.

## Test plan
- Reset with `irq` held high: all outputs 0. Release `rst_n` with `irq` still high: no edge is detected and no take occurs.
- en=3'b001, pulse `irq`, `inst_done`=1 on every cen:
  - `irq_take` is high for 1 cen, `irq_src`=1 and `iack` is high for 2 cen.
  - `pioc_dout`=16'h0041 during service.
  - After `ireturn`, `pioc_dout`=16'h0001.
- en=3'b111 with `siord_full`=1, `siowr_empty`=1 and an `irq` edge on the same cycle: takes occur in order IRQ (src 1), then after `ireturn` IBF (src 2). OBE is taken only when `siord_full` drops.
- `irq` edge with en=0: pend[0]=1 (`pioc_dout`=16'h0008) and no take. Write en=1: take follows at the next cen with `inst_done`. A repeat with `pioc_din`=16'h0100 clears pend with no take.
- `ireturn` and an active request on the same cen: `shadow` falls, and `irq_take` does not rise until the following cen with `inst_done`.
- Assert `rst_n` low while `iack` and `shadow` are high: both are 0 immediately (asynchronous), and `irq_src`=0.
